// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared fetch-stage types, widths and opcode helper
package processor_pkg;
    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 27;

    typedef enum logic [1:0] {
        WARMUP,
        FETCH,
        HALTED
    } fetch_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction
endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with load-target, increment and hold
module program_counter
    import processor_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Load outranks increment so a redirect always lands on the target.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, instruction register, stall/branch/halt/fault
module instruction_fetch
    import processor_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned           MEM_DEPTH = 41
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  instruction_address,
    input  logic [INSTR_WIDTH-1:0] instruction_data,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt,
    output logic [INSTR_WIDTH-1:0] instruction_register,
    output logic [ADDR_WIDTH-1:0]  instruction_pc,
    output logic                   instruction_valid,
    output logic                   halted,
    output logic                   fetch_fault
);
    fetch_state_t           state_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0]  ipc_q;
    logic                   valid_q;
    logic                   halted_q;
    logic                   fault_q;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   in_fetch;
    logic                   in_range;
    logic                   pc_load;
    logic                   pc_inc;

    assign in_fetch = (state_q == FETCH);
    assign in_range = (pc < ADDR_WIDTH'(MEM_DEPTH));
    assign pc_load  = in_fetch && !halt && branch_taken;
    assign pc_inc   = in_fetch && !halt && !branch_taken && !stall && in_range;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (pc_load),
        .target_i (branch_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    // Priority inside FETCH is halt > branch > stall > sequential fetch/fault.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= WARMUP;
            ir_q     <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                WARMUP: state_q <= FETCH;
                FETCH: begin
                    if (halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                        valid_q  <= 1'b0;
                    end else if (branch_taken) begin
                        valid_q <= 1'b0;
                    end else if (stall) begin
                    end else if (in_range) begin
                        ir_q    <= instruction_data;
                        ipc_q   <= pc;
                        valid_q <= 1'b1;
                    end else begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                        valid_q  <= 1'b0;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instruction_address  = pc;
    assign instruction_register = ir_q;
    assign instruction_pc       = ipc_q;
    assign instruction_valid    = valid_q;
    assign halted               = halted_q;
    assign fetch_fault          = fault_q;
endmodule
